// File: rtl/delay_timer_pkg.sv
// Shared definitions for the delay timer: mode encodings, FSM states and default widths.
// Also holds the small helpers used by the top level.
package delay_timer_pkg;

   localparam int N_BITS_DEFAULT = 16;
   localparam int P_BITS_DEFAULT = 8;

   typedef enum logic [1:0] {
      MODE_ONESHOT     = 2'd0,
      MODE_RETRIG      = 2'd1,
      MODE_PERIODIC    = 2'd2,
      MODE_ONESHOT_ALT = 2'd3
   } mode_t;

   typedef enum logic {
      ST_IDLE,
      ST_COUNT
   } state_t;

   // Encoding 3 has no behaviour of its own and folds onto one-shot.
   function automatic mode_t normalize_mode(input logic [1:0] raw);
      mode_t m;
      m = mode_t'(raw);
      if (m == MODE_ONESHOT_ALT) begin
         m = MODE_ONESHOT;
      end
      return m;
   endfunction

endpackage

// File: rtl/delay_prescaler.sv
// Prescale down-counter: divides the clock so that one tick occurs every prescale+1 enabled clocks.
// The caller supplies the load value on start and the reload value while counting.
module delay_prescaler #(
   parameter int P_BITS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              enable,
   input  logic [P_BITS-1:0] prescale,
   output logic              tick
);

   logic [P_BITS-1:0] pre;

   assign tick = enable && (pre == '0);

   // A tick consumes the zero state and immediately reloads for the next tick period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre <= '0;
      end else if (load) begin
         pre <= prescale;
      end else if (enable) begin
         if (pre == '0) begin
            pre <= prescale;
         end else begin
            pre <= pre - 1'b1;
         end
      end
   end

endmodule

// File: rtl/delay_timer.sv
// Programmable tick-count delay with one-shot, retriggerable and periodic modes.
// Produces a one-clock timeout strobe and exposes busy/remaining status.
module delay_timer
   import delay_timer_pkg::*;
#(
   parameter int N_BITS = N_BITS_DEFAULT,
   parameter int P_BITS = P_BITS_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trigger,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic [N_BITS-1:0] n,
   input  logic [P_BITS-1:0] prescale,
   output logic              busy,
   output logic              timeout,
   output logic [N_BITS-1:0] remaining
);

   state_t            state;
   mode_t             mode_lat;
   logic [N_BITS-1:0] n_lat;
   logic [P_BITS-1:0] pre_lat;
   logic [N_BITS-1:0] count;

   logic [N_BITS-1:0] n_eff;
   logic              accept;
   logic              pre_load;
   logic              pre_enable;
   logic [P_BITS-1:0] pre_value;
   logic              tick;

   assign n_eff = (n == '0) ? N_BITS'(1) : n;

   // Only a running retriggerable countdown lets a new trigger in while busy.
   assign accept = trigger && ((state == ST_IDLE) || (mode_lat == MODE_RETRIG));

   // Abort forces the prescaler to zero; a start loads the fresh prescale.
   assign pre_load   = abort || accept;
   assign pre_value  = abort ? '0 : (accept ? prescale : pre_lat);
   assign pre_enable = (state == ST_COUNT) && !pre_load;

   delay_prescaler #(
      .P_BITS (P_BITS)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .load     (pre_load),
      .enable   (pre_enable),
      .prescale (pre_value),
      .tick     (tick)
   );

   // Control FSM: abort beats trigger, trigger beats the tick/expiry path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         count    <= '0;
         timeout  <= 1'b0;
         mode_lat <= MODE_ONESHOT;
         n_lat    <= '0;
         pre_lat  <= '0;
      end else begin
         timeout <= 1'b0;
         if (abort) begin
            state <= ST_IDLE;
            count <= '0;
         end else if (accept) begin
            state    <= ST_COUNT;
            count    <= n_eff;
            mode_lat <= normalize_mode(mode);
            n_lat    <= n_eff;
            pre_lat  <= prescale;
         end else if ((state == ST_COUNT) && tick) begin
            if (count == N_BITS'(1)) begin
               timeout <= 1'b1;
               if (mode_lat == MODE_PERIODIC) begin
                  count <= n_lat;
               end else begin
                  state <= ST_IDLE;
                  count <= '0;
               end
            end else begin
               count <= count - 1'b1;
            end
         end
      end
   end

   assign busy      = (state == ST_COUNT);
   assign remaining = count;

endmodule

// File: tb/tb_delay_timer.sv
// Scoreboard bench for delay_timer: expected timeout edges are queued when triggers are driven
// and matched against observed strobes; status outputs are checked at chosen edges.
module tb_delay_timer;

   localparam int N_BITS = 16;
   localparam int P_BITS = 8;

   logic              clk;
   logic              rst;
   logic              trigger;
   logic              abort;
   logic [1:0]        mode;
   logic [N_BITS-1:0] n;
   logic [P_BITS-1:0] prescale;
   logic              busy;
   logic              timeout;
   logic [N_BITS-1:0] remaining;

   int num_checks = 0;
   int num_fails  = 0;
   int cyc        = 0;
   int exp_q[$];

   delay_timer #(
      .N_BITS (N_BITS),
      .P_BITS (P_BITS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .trigger   (trigger),
      .abort     (abort),
      .mode      (mode),
      .n         (n),
      .prescale  (prescale),
      .busy      (busy),
      .timeout   (timeout),
      .remaining (remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute posedge counter; after edge e it reads e.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      num_checks++;
      if (observed !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, observed, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic trig, input logic ab, input logic [1:0] md,
                                input int nn, input int ps);
      trigger  = trig;
      abort    = ab;
      mode     = md;
      n        = N_BITS'(nn);
      prescale = P_BITS'(ps);
   endtask

   // Called at a negedge; the trigger is sampled at the next edge, whose number is returned.
   task automatic pulseTrigger(input logic [1:0] md, input int nn, input int ps, output int k);
      k = cyc + 1;
      applyStimulus(1'b1, 1'b0, md, nn, ps);
      @(negedge clk);
      trigger = 1'b0;
   endtask

   task automatic waitEdge(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   task automatic checkDrained(input string tag);
      checkOutput(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Every observed strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && timeout) begin
         if (exp_q.size() == 0) begin
            checkOutput("spurious_timeout", int'(timeout), 0);
         end else begin
            checkOutput("timeout_edge", cyc, exp_q.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int k;
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 2'd0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_timeout", int'(timeout), 0);
      checkOutput("reset_remaining", int'(remaining), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // One-shot n=5, prescale 0: remaining walks 5..0, expiry at k+5.
      $display("[TB] one-shot basic");
      exp_q.push_back(cyc + 1 + 5);
      pulseTrigger(2'd0, 5, 0, k);
      for (int i = 0; i <= 5; i++) begin
         waitEdge(k + i);
         checkOutput($sformatf("t1_remaining_%0d", i), int'(remaining), 5 - i);
         checkOutput($sformatf("t1_busy_%0d", i), int'(busy), (i < 5) ? 1 : 0);
      end
      waitEdge(k + 7);
      checkDrained("t1_drained");

      // One-shot n=3, prescale 3: expiry at k+12, a trigger at k+6 is ignored.
      $display("[TB] one-shot with prescale, ignored retrigger");
      exp_q.push_back(cyc + 1 + 12);
      pulseTrigger(2'd0, 3, 3, k);
      waitEdge(k + 5);
      pulseTrigger(2'd1, 9, 0, k);
      checkOutput("t2_remaining_k6", int'(remaining), 2);
      waitEdge(k + 8);
      checkOutput("t2_busy_after", int'(busy), 0);
      checkDrained("t2_drained");

      // Retriggerable n=4: retrigger at k+3 pushes expiry to k+7.
      $display("[TB] retriggerable");
      exp_q.push_back(cyc + 1 + 7);
      pulseTrigger(2'd1, 4, 0, k);
      waitEdge(k + 2);
      pulseTrigger(2'd1, 4, 0, k);
      checkOutput("t3a_remaining_reload", int'(remaining), 4);
      waitEdge(k + 6);
      checkDrained("t3a_drained");

      // Retrigger landing on the expiry edge wins; the reloaded count expires at k+8.
      exp_q.push_back(cyc + 1 + 8);
      pulseTrigger(2'd1, 4, 0, k);
      waitEdge(k + 3);
      pulseTrigger(2'd1, 4, 0, k);
      checkOutput("t3b_remaining_reload", int'(remaining), 4);
      checkOutput("t3b_busy_reload", int'(busy), 1);
      waitEdge(k + 6);
      checkDrained("t3b_drained");

      // Periodic n=2, prescale 1: strobes at k+4, k+8, k+12; abort at k+14.
      $display("[TB] periodic with abort");
      k = cyc + 1;
      exp_q.push_back(k + 4);
      exp_q.push_back(k + 8);
      exp_q.push_back(k + 12);
      pulseTrigger(2'd2, 2, 1, k);
      waitEdge(k + 13);
      applyStimulus(1'b0, 1'b1, 2'd2, 2, 1);
      @(negedge clk);
      abort = 1'b0;
      checkOutput("t4_busy_abort", int'(busy), 0);
      checkOutput("t4_remaining_abort", int'(remaining), 0);
      waitEdge(k + 22);
      checkDrained("t4_drained");

      // n=0 behaves as n=1: expiry at k+1.
      $display("[TB] zero count and abort on expiry");
      exp_q.push_back(cyc + 1 + 1);
      pulseTrigger(2'd0, 0, 0, k);
      checkOutput("t5a_remaining", int'(remaining), 1);
      waitEdge(k + 3);
      checkDrained("t5a_drained");

      // Abort coinciding with the expiry edge suppresses the strobe.
      pulseTrigger(2'd0, 3, 0, k);
      waitEdge(k + 2);
      applyStimulus(1'b0, 1'b1, 2'd0, 3, 0);
      @(negedge clk);
      abort = 1'b0;
      checkOutput("t5b_busy", int'(busy), 0);
      waitEdge(k + 6);
      checkDrained("t5b_drained");

      // Mode 3 with trigger held: expiry at k+2, restart at k+3, second expiry at k+5.
      $display("[TB] held trigger, mode 3");
      k = cyc + 1;
      exp_q.push_back(k + 2);
      exp_q.push_back(k + 5);
      applyStimulus(1'b1, 1'b0, 2'd3, 2, 0);
      waitEdge(k + 3);
      trigger = 1'b0;
      checkOutput("t7_remaining_restart", int'(remaining), 2);
      waitEdge(k + 8);
      checkOutput("t7_busy_end", int'(busy), 0);
      checkDrained("t7_drained");

      // Asynchronous reset mid-countdown, then a clean restart.
      $display("[TB] async reset mid-count");
      pulseTrigger(2'd0, 100, 0, k);
      waitEdge(k + 50);
      checkOutput("t6_remaining_mid", int'(remaining), 50);
      #2 rst = 1'b1;
      #1;
      checkOutput("t6_busy_rst", int'(busy), 0);
      checkOutput("t6_timeout_rst", int'(timeout), 0);
      checkOutput("t6_remaining_rst", int'(remaining), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exp_q.push_back(cyc + 1 + 6);
      pulseTrigger(2'd0, 3, 1, k);
      checkOutput("t6_remaining_restart", int'(remaining), 3);
      checkOutput("t6_busy_restart", int'(busy), 1);
      waitEdge(k + 8);
      checkDrained("t6_drained");

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
